// File: rtl/coax_tx_arbiter.sv
// rtl/coax_tx_arbiter.sv - two-source frame arbiter for the coax TX FIFO/serializer
// Keeps each granted frame atomic from first word through transmit completion.
module coax_tx_arbiter #(
   parameter int MAX_WORDS     = 64,
   parameter int START_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] load,
   input  logic [1:0] last,
   input  logic [9:0] data0,
   input  logic [9:0] data1,
   input  logic       clear,
   input  logic       tx_active,
   input  logic       tx_full,
   output logic [1:0] grant,
   output logic [1:0] done,
   output logic [1:0] abort,
   output logic [1:0] overflow,
   output logic       timeout,
   output logic [9:0] tx_data,
   output logic       tx_load_strobe,
   output logic       tx_start_strobe,
   output logic       tx_reset
);
   localparam int CW = $clog2(MAX_WORDS + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);
   localparam logic [7:0]    TMO     = 8'(START_TIMEOUT);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_RISE, WAIT_FALL, ABORT} state_t;

   state_t        state, state_nxt;
   logic          owner, owner_nxt;
   logic          last_served, last_served_nxt;
   logic [CW-1:0] word_cnt, word_cnt_nxt;
   logic [7:0]    tmr, tmr_nxt;
   logic [1:0]    grant_nxt, done_nxt, abort_nxt, overflow_nxt, ov_set;
   logic          timeout_nxt, tmo_set;
   logic [9:0]    tx_data_nxt;
   logic          load_nxt, start_nxt, txrst_nxt;
   logic          win;
   logic [1:0]    sel;

   always_comb begin
      state_nxt       = state;
      owner_nxt       = owner;
      last_served_nxt = last_served;
      word_cnt_nxt    = word_cnt;
      tmr_nxt         = tmr;
      grant_nxt       = grant;
      done_nxt        = 2'b00;
      abort_nxt       = 2'b00;
      ov_set          = 2'b00;
      tmo_set         = 1'b0;
      tx_data_nxt     = tx_data;
      load_nxt        = 1'b0;
      start_nxt       = 1'b0;
      txrst_nxt       = 1'b0;
      win             = 1'b0;
      sel             = owner ? 2'b10 : 2'b01;

      case (state)
         IDLE: begin
            // A foreign transmission already on the line blocks arbitration.
            if (req != 2'b00 && !tx_active) begin
               win          = (req == 2'b11) ? ~last_served : req[1];
               owner_nxt    = win;
               grant_nxt    = win ? 2'b10 : 2'b01;
               word_cnt_nxt = '0;
               state_nxt    = LOAD;
            end
         end
         LOAD: begin
            if (!req[owner]) begin
               state_nxt = ABORT;
            end else if (load[owner]) begin
               if (word_cnt == MAX_CNT) begin
                  state_nxt = ABORT;
               end else if (tx_full) begin
                  ov_set = sel;
               end else begin
                  load_nxt     = 1'b1;
                  tx_data_nxt  = owner ? data1 : data0;
                  word_cnt_nxt = word_cnt + CW'(1);
                  if (last[owner]) state_nxt = START;
               end
            end
         end
         START: begin
            start_nxt = 1'b1;
            grant_nxt = 2'b00;
            tmr_nxt   = '0;
            state_nxt = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (tx_active) begin
               state_nxt = WAIT_FALL;
            end else if (tmr == TMO) begin
               tmo_set   = 1'b1;
               state_nxt = ABORT;
            end else begin
               tmr_nxt = tmr + 8'd1;
            end
         end
         WAIT_FALL: begin
            if (!tx_active) begin
               done_nxt        = sel;
               last_served_nxt = owner;
               state_nxt       = IDLE;
            end
         end
         ABORT: begin
            // tx_reset flushes whatever part of the frame reached the FIFO.
            txrst_nxt       = 1'b1;
            abort_nxt       = sel;
            grant_nxt       = 2'b00;
            last_served_nxt = owner;
            state_nxt       = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      overflow_nxt = (clear ? 2'b00 : overflow) | ov_set;
      timeout_nxt  = (clear ? 1'b0 : timeout) | tmo_set;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         owner           <= 1'b0;
         last_served     <= 1'b1;
         word_cnt        <= '0;
         tmr             <= '0;
         grant           <= 2'b00;
         done            <= 2'b00;
         abort           <= 2'b00;
         overflow        <= 2'b00;
         timeout         <= 1'b0;
         tx_data         <= '0;
         tx_load_strobe  <= 1'b0;
         tx_start_strobe <= 1'b0;
         tx_reset        <= 1'b0;
      end else begin
         state           <= state_nxt;
         owner           <= owner_nxt;
         last_served     <= last_served_nxt;
         word_cnt        <= word_cnt_nxt;
         tmr             <= tmr_nxt;
         grant           <= grant_nxt;
         done            <= done_nxt;
         abort           <= abort_nxt;
         overflow        <= overflow_nxt;
         timeout         <= timeout_nxt;
         tx_data         <= tx_data_nxt;
         tx_load_strobe  <= load_nxt;
         tx_start_strobe <= start_nxt;
         tx_reset        <= txrst_nxt;
      end
   end
endmodule

// File: tb/tb_coax_tx_arbiter.sv
// tb/tb_coax_tx_arbiter.sv - scoreboard bench for coax_tx_arbiter
// Driver pushes expected TX events from a frame-level model; monitor pops and compares.
module tb_coax_tx_arbiter;
   localparam int MAX_WORDS = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] req = '0, load = '0, last = '0;
   logic [9:0] data0 = '0, data1 = '0;
   logic       clear = 1'b0, tx_active = 1'b0, tx_full = 1'b0;
   logic [1:0] grant, done, abort, overflow;
   logic       timeout, tx_load_strobe, tx_start_strobe, tx_reset;
   logic [9:0] tx_data;

   coax_tx_arbiter #(.MAX_WORDS(MAX_WORDS), .START_TIMEOUT(255)) dut (
      .clk(clk), .reset(reset), .req(req), .load(load), .last(last),
      .data0(data0), .data1(data1), .clear(clear), .tx_active(tx_active),
      .tx_full(tx_full), .grant(grant), .done(done), .abort(abort),
      .overflow(overflow), .timeout(timeout), .tx_data(tx_data),
      .tx_load_strobe(tx_load_strobe), .tx_start_strobe(tx_start_strobe),
      .tx_reset(tx_reset)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] kind;
      logic [1:0] who;
      logic [9:0] data;
   } ev_t;
   localparam logic [1:0] EV_LOAD = 2'd0, EV_START = 2'd1, EV_DONE = 2'd2, EV_ABORT = 2'd3;

   ev_t        exp_q[$];
   logic [9:0] fixed_q[$];
   int         checks = 0;
   int         errors = 0;
   logic       m_last_served = 1'b1;
   logic [1:0] m_ovf = 2'b00;
   logic       m_tmo = 1'b0;
   logic [1:0] r;
   logic       w;

   function automatic ev_t mk(input logic [1:0] kind, input logic [1:0] who, input logic [9:0] data);
      ev_t e;
      e.kind = kind; e.who = who; e.data = data;
      return e;
   endfunction

   function automatic logic [1:0] oh(input logic x);
      return x ? 2'b10 : 2'b01;
   endfunction

   // Round robin: on a tie the requester not served last wins.
   function automatic logic model_winner(input logic [1:0] rq);
      if (rq == 2'b11) return ~m_last_served;
      return rq[1];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic observe(input ev_t a);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d who=%b data=%h, expected none", a.kind, a.who, a.data);
      end else begin
         e = exp_q.pop_front();
         if (a !== e) begin
            errors++;
            $display("FAIL scoreboard: got kind=%0d who=%b data=%h, expected kind=%0d who=%b data=%h",
                     a.kind, a.who, a.data, e.kind, e.who, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (tx_load_strobe)  observe(mk(EV_LOAD, grant, tx_data));
         if (tx_start_strobe) observe(mk(EV_START, grant, 10'h0));
         if (done != 2'b00)   observe(mk(EV_DONE, done, 10'h0));
         if (abort != 2'b00)  observe(mk(EV_ABORT, abort, 10'h0));
         if (tx_reset || abort != 2'b00) check("tx_reset_with_abort", 32'(tx_reset), 32'(abort != 2'b00));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input logic x);
      int n = 0;
      while (grant == 2'b00 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("grant", 32'(grant), 32'(oh(x)));
   endtask

   task automatic wait_end(input int limit);
      int n = 0;
      while (done == 2'b00 && abort == 2'b00 && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL frame_end: no done/abort after %0d cycles, required within %0d", n, limit);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_ovf = 2'b00;
      m_tmo = 1'b0;
   endtask

   task automatic run_frame(input logic x, input int n, input int abort_at, input int full_idx,
                            input bit tmo, input bit noise);
      logic [9:0] d;
      int k;
      bit aborted;
      aborted = 0;
      wait_grant(x);
      tick();
      for (int i = 0; i < n && !aborted; i++) begin
         if (i == abort_at) begin
            req[x] = 1'b0;
            exp_q.push_back(mk(EV_ABORT, oh(x), 10'h0));
            aborted = 1;
         end else begin
            d = (fixed_q.size() != 0) ? fixed_q.pop_front() : 10'($urandom);
            if (x) data1 = d; else data0 = d;
            load[x] = 1'b1;
            last[x] = (i == n - 1);
            tx_full = (i == full_idx);
            if (noise) begin
               load[!x] = 1'($urandom);
               last[!x] = 1'($urandom);
               if (x) data0 = 10'($urandom); else data1 = 10'($urandom);
            end
            if (i >= MAX_WORDS) begin
               exp_q.push_back(mk(EV_ABORT, oh(x), 10'h0));
               aborted = 1;
            end else if (i == full_idx) begin
               m_ovf[x] = 1'b1;
            end else begin
               exp_q.push_back(mk(EV_LOAD, oh(x), d));
               if (i == n - 1) exp_q.push_back(mk(EV_START, 2'b00, 10'h0));
            end
            tick();
            load = 2'b00;
            last = 2'b00;
            tx_full = 1'b0;
            if (aborted) req[x] = 1'b0;
            else if (i != n - 1) repeat ($urandom_range(0, 2)) tick();
         end
      end
      if (aborted) begin
         wait_end(10);
      end else begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!tx_start_strobe && k < 6);
         check("start_latency", 32'(k), 32'd2);
         tick();
         req[x] = 1'b0;
         if (tmo) begin
            exp_q.push_back(mk(EV_ABORT, oh(x), 10'h0));
            m_tmo = 1'b1;
            wait_end(300);
            check("timeout_at_abort", 32'(timeout), 32'd1);
         end else begin
            repeat ($urandom_range(0, 3)) tick();
            tx_active = 1'b1;
            exp_q.push_back(mk(EV_DONE, oh(x), 10'h0));
            repeat ($urandom_range(1, 4)) tick();
            tx_active = 1'b0;
            wait_end(10);
         end
      end
      m_last_served = x;
      tick();
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("timeout", 32'(timeout), 32'(m_tmo));
      if ($urandom_range(0, 2) == 0) do_clear();
   endtask

   task automatic rand_frame(input logic x);
      int n, ab, fi;
      n  = $urandom_range(1, 6);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      fi = (n > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 2)) : -1;
      run_frame(x, n, ab, fi, 1'b0, 1'b1);
   endtask

   function automatic logic [21:0] outvec();
      return {grant, done, abort, overflow, timeout, tx_data, tx_load_strobe, tx_start_strobe, tx_reset};
   endfunction

   initial begin
      #3;
      check("reset_outputs", 32'(outvec()), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      fixed_q.push_back(10'h201);
      fixed_q.push_back(10'h0AA);
      fixed_q.push_back(10'h155);
      req = 2'b01;
      run_frame(1'b0, 3, -1, -1, 1'b0, 1'b0);

      repeat (2) begin
         req = 2'b11;
         w = model_winner(req);
         run_frame(w, 3, -1, -1, 1'b0, 1'b1);
         w = model_winner(req);
         run_frame(w, 2, -1, -1, 1'b0, 1'b1);
      end

      req = 2'b01;
      run_frame(1'b0, 3, -1, 1, 1'b0, 1'b0);
      do_clear();
      check("overflow_cleared", 32'(overflow), 32'd0);

      req = 2'b01;
      run_frame(1'b0, 2, -1, -1, 1'b1, 1'b0);
      do_clear();
      check("timeout_cleared", 32'(timeout), 32'd0);

      req = 2'b10;
      tick();
      req = 2'b11;
      run_frame(1'b1, 4, 2, -1, 1'b0, 1'b0);
      run_frame(model_winner(req), 2, -1, -1, 1'b0, 1'b0);

      req = 2'b01;
      run_frame(1'b0, MAX_WORDS + 1, -1, -1, 1'b0, 1'b0);

      tx_active = 1'b1;
      req = 2'b01;
      repeat (5) tick();
      check("no_grant_while_active", 32'(grant), 32'd0);
      tx_active = 1'b0;
      run_frame(1'b0, 2, -1, -1, 1'b0, 1'b0);

      for (int it = 0; it < 30; it++) begin
         r = 2'($urandom_range(1, 3));
         req = r;
         w = model_winner(r);
         rand_frame(w);
         if (r == 2'b11) begin
            w = model_winner(req);
            rand_frame(w);
         end
      end

      req = 2'b01;
      wait_grant(1'b0);
      tick();
      load[0] = 1'b1;
      data0 = 10'h03C;
      tx_full = 1'b1;
      m_ovf[0] = 1'b1;
      tick();
      load = 2'b00;
      tx_full = 1'b0;
      check("overflow_before_reset", 32'(overflow), 32'(m_ovf));
      #2 reset = 1'b1;
      #1;
      check("async_reset_outputs", 32'(outvec()), 32'd0);
      req = 2'b00;
      m_ovf = 2'b00;
      m_tmo = 1'b0;
      m_last_served = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      req = 2'b11;
      w = model_winner(req);
      run_frame(w, 2, -1, -1, 1'b0, 1'b0);
      run_frame(model_winner(req), 2, -1, -1, 1'b0, 1'b0);

      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
